// File: rtl/btb_update_ctrl.sv
// Branch-resolution update controller: queues resolved branches for the BTB/predictor
// update port and drives the fetch redirect/flush sequence on a mispredict.
`timescale 1ns/1ps
module btb_update_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Handshake: a record transfers on a rising clk edge where res_valid && res_ready;
    // res_ready depends only on internal state, never combinationally on res_valid.
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [31:0]      res_pc,
    input  logic [31:0]      res_target,
    input  logic             res_taken,
    input  logic             res_pred_taken,
    input  logic [31:0]      res_pred_target,
    input  logic [1:0]       res_state,
    input  logic             upd_hold,
    output logic             upd_en,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic [1:0]       upd_state,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  st;
    } rec_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
    rec_t              mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    rec_t              upd_q;
    logic              upd_en_q;
    logic [31:0]       redirect_pc_q;
    logic [CNT_W-1:0]  branch_cnt_q, mispredict_cnt_q;

    logic fifo_full, fifo_empty, push, pop, mispredict;

    assign fifo_full  = (count_q == COUNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign res_ready  = !fifo_full && (state_q == S_IDLE);
    assign push       = res_valid && res_ready;
    assign pop        = !fifo_empty && !upd_hold;
    assign mispredict = (res_taken != res_pred_taken) ||
                        (res_taken && (res_pred_target != res_target));

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + COUNT_ONE;
        else if (!push && pop) count_d = count_q - COUNT_ONE;
    end

    // Storage carries no reset; validity is tracked entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{pc: res_pc, target: res_target,
                                       taken: res_taken, st: res_state};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            upd_q    <= '0;
            upd_en_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            upd_en_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                upd_q    <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            flush_cnt_q      <= '0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (push && mispredict)
                redirect_pc_q <= res_taken ? res_target : (res_pc + 32'd4);
            if (push && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + 1'b1;
            if (push && mispredict && (mispredict_cnt_q != '1))
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (push && mispredict) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                // Counter holds the flush cycles still owed, including this one.
                if (flush_cnt_q <= FLUSH_ONE) state_d = S_IDLE;
                else                          flush_cnt_d = flush_cnt_q - FLUSH_ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign redirect_valid = (state_q == S_REDIRECT);
    assign flush          = (state_q != S_IDLE);
    assign redirect_pc    = redirect_pc_q;
    assign upd_en         = upd_en_q;
    assign upd_pc         = upd_q.pc;
    assign upd_target     = upd_q.target;
    assign upd_taken      = upd_q.taken;
    assign upd_state      = upd_q.st;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_btb_update_ctrl;

    localparam int DEPTH = 4;
    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  st;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [31:0]   res_pc = '0, res_target = '0, res_pred_target = '0;
    logic          res_taken = 1'b0, res_pred_taken = 1'b0;
    logic [1:0]    res_state = '0;
    logic          upd_hold = 1'b0;
    logic          upd_en, upd_taken, redirect_valid, flush;
    logic [31:0]   upd_pc, upd_target, redirect_pc;
    logic [1:0]    upd_state, dbg_state;
    logic [CW-1:0] branch_cnt, mispredict_cnt;

    int checks = 0;
    int errors = 0;

    btb_update_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .res_state(res_state), .upd_hold(upd_hold),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_state(upd_state),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // behavioural model: a queue of pending updates and a busy-cycle countdown
    rec_t m_q[$];
    rec_t m_upd = '0;
    bit   m_upd_en = 0;
    int   m_busy = 0;
    logic [31:0] m_redir_pc = '0;
    int   m_bcnt = 0, m_mcnt = 0;

    always @(posedge clk or posedge rst) begin : model_step
        bit acc, pop, mis;
        if (rst) begin
            m_q.delete();
            m_upd = '0; m_upd_en = 0; m_busy = 0; m_redir_pc = '0;
            m_bcnt = 0; m_mcnt = 0;
        end else begin
            acc = res_valid && (m_busy == 0) && (m_q.size() < DEPTH);
            pop = (m_q.size() > 0) && !upd_hold;
            mis = (res_taken != res_pred_taken) ||
                  (res_taken && (res_pred_target != res_target));
            m_upd_en = pop;
            if (pop) m_upd = m_q.pop_front();
            if (m_busy > 0) m_busy--;
            if (acc) begin
                m_q.push_back('{pc: res_pc, target: res_target, taken: res_taken, st: res_state});
                if (m_bcnt < CMAX) m_bcnt++;
                if (mis) begin
                    if (m_mcnt < CMAX) m_mcnt++;
                    m_busy = FC;
                    m_redir_pc = res_taken ? res_target : res_pc + 32'd4;
                end
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_res_ready", res_ready, (m_busy == 0) && (m_q.size() < DEPTH));
            chk("m_upd_en", upd_en, m_upd_en);
            chk("m_upd_pc", upd_pc, m_upd.pc);
            chk("m_upd_target", upd_target, m_upd.target);
            chk("m_upd_taken", upd_taken, m_upd.taken);
            chk("m_upd_state", upd_state, m_upd.st);
            chk("m_redirect_valid", redirect_valid, m_busy == FC);
            chk("m_flush", flush, m_busy > 0);
            chk("m_redirect_pc", redirect_pc, m_redir_pc);
            chk("m_branch_cnt", branch_cnt, m_bcnt);
            chk("m_mispredict_cnt", mispredict_cnt, m_mcnt);
        end
    end

    // driver tasks
    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic ptk, input logic [31:0] ptgt, input logic [1:0] st);
        res_valid = 1'b1; res_pc = pc; res_target = tgt; res_taken = tk;
        res_pred_taken = ptk; res_pred_target = ptgt; res_state = st;
    endtask

    task automatic idle_in();
        res_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_upd_en", upd_en, 0);
        chk("rst_upd_pc", upd_pc, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0;
        #1 chk("ready_after_rst", res_ready, 1);

        // correct prediction
        @(negedge clk); send(32'h100, 32'h200, 1, 1, 32'h200, 2);
        @(negedge clk); idle_in();
        chk("cp_upd_en_early", upd_en, 0);
        chk("cp_no_redirect", redirect_valid, 0);
        @(negedge clk);
        chk("cp_upd_en", upd_en, 1);
        chk("cp_upd_pc", upd_pc, 32'h100);
        chk("cp_upd_target", upd_target, 32'h200);
        chk("cp_upd_taken", upd_taken, 1);
        chk("cp_upd_state", upd_state, 2);
        chk("cp_branch_cnt", branch_cnt, 1);
        chk("cp_mis_cnt", mispredict_cnt, 0);
        chk("cp_no_flush", flush, 0);

        // direction mispredict
        @(negedge clk); send(32'h40, 32'h80, 0, 1, 32'h80, 1);
        @(negedge clk); idle_in();
        chk("dm_redirect_valid", redirect_valid, 1);
        chk("dm_redirect_pc", redirect_pc, 32'h44);
        chk("dm_flush1", flush, 1);
        chk("dm_ready1", res_ready, 0);
        @(negedge clk);
        chk("dm_redirect_off", redirect_valid, 0);
        chk("dm_flush2", flush, 1);
        chk("dm_ready2", res_ready, 0);
        chk("dm_upd_pc", upd_pc, 32'h40);
        @(negedge clk);
        chk("dm_flush_end", flush, 0);
        chk("dm_ready_back", res_ready, 1);
        chk("dm_mis_cnt", mispredict_cnt, 1);

        // target mispredict
        @(negedge clk); send(32'h500, 32'h380, 1, 1, 32'h300, 3);
        @(negedge clk); idle_in();
        chk("tm_redirect_valid", redirect_valid, 1);
        chk("tm_redirect_pc", redirect_pc, 32'h380);
        @(negedge clk);
        chk("tm_upd_en", upd_en, 1);
        chk("tm_upd_target", upd_target, 32'h380);
        repeat (2) @(negedge clk);

        // backpressure
        upd_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", res_ready, i < 4);
            send(32'h1000 + 32'(4*i), 32'h2000 + 32'(4*i), 1, 1, 32'h2000 + 32'(4*i), 2'(i));
        end
        @(negedge clk);
        chk("bp_full", res_ready, 0);
        idle_in(); upd_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_drain_en", upd_en, 1);
            chk("bp_drain_pc", upd_pc, 32'h1000 + 32'(4*i));
        end
        @(negedge clk);
        chk("bp_drain_done", upd_en, 0);
        chk("bp_branch_cnt", branch_cnt, 7);

        // reset in the middle of a flush with two queued updates
        upd_hold = 1'b1;
        @(negedge clk); send(32'h600, 32'h700, 1, 1, 32'h700, 1);
        @(negedge clk); send(32'h610, 32'h800, 0, 1, 32'h800, 0);
        @(negedge clk); idle_in();
        chk("rf_redirect", redirect_valid, 1);
        @(negedge clk);
        chk("rf_in_flush", flush, 1);
        #2 rst = 1'b1;
        #1;
        chk("rf_flush_off", flush, 0);
        chk("rf_upd_en", upd_en, 0);
        chk("rf_branch_cnt", branch_cnt, 0);
        chk("rf_mis_cnt", mispredict_cnt, 0);
        chk("rf_redirect_pc", redirect_pc, 0);
        @(negedge clk); rst = 1'b0; upd_hold = 1'b0;
        #1 chk("rf_ready", res_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rf_fifo_empty", upd_en, 0);
        end

        // counter saturation
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("sat_ready", res_ready, 1);
            send(32'h3000 + 32'(4*i), 32'h4000, 1, 1, 32'h4000, 3);
        end
        @(negedge clk); idle_in();
        chk("sat_branch_cnt", branch_cnt, 15);
        chk("sat_mis_cnt", mispredict_cnt, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            res_valid = ($urandom_range(0, 99) < 70);
            upd_hold  = ($urandom_range(0, 99) < 30);
            res_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            res_taken = 1'($urandom_range(0, 1));
            res_pred_taken = ($urandom_range(0, 99) < 20) ? ~res_taken : res_taken;
            res_target = $urandom;
            res_pred_target = ($urandom_range(0, 99) < 15) ? $urandom : res_target;
            res_state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        @(negedge clk); idle_in(); upd_hold = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
